cliente_cajero: RTL and testbench

Customer-side transaction driver for the ATM controller `laboratorio2`. It takes one complete request from a host: card type, 4-digit PIN, transaction type and amount. It then plays it into the controller's input protocol: card insert, PIN digits one strobe at a time, and the amount strobe. It watches the controller's response flags and reports a single result code, so benches and the system top can run transactions without hand-sequencing strobes.

---
 rtl/cajero_pkg.sv | 45 ++++
 rtl/cliente_cajero_serializador_pin.sv | 62 ++++++
 rtl/cliente_cajero.sv | 201 ++++++++++++++++++++
 tb/tb_cliente_cajero.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cajero_pkg.sv
// Shared types and constants for the ATM customer-side transaction driver.
package cajero_pkg;

    localparam int unsigned PIN_W     = 16;
    localparam int unsigned MONTO_W   = 32;
    localparam int unsigned DIGITO_W  = 4;
    localparam int unsigned N_DIGITOS = PIN_W / DIGITO_W;
    localparam int unsigned RES_W     = 3;

    // Result codes reported with done
    localparam logic [RES_W-1:0] RES_OK      = 3'd0;
    localparam logic [RES_W-1:0] RES_PIN_BAD = 3'd1;
    localparam logic [RES_W-1:0] RES_BLOCKED = 3'd2;
    localparam logic [RES_W-1:0] RES_NOFUNDS = 3'd3;
    localparam logic [RES_W-1:0] RES_TIMEOUT = 3'd4;

    // Transaction types
    localparam logic TRANS_DEPOSITO = 1'b0;
    localparam logic TRANS_RETIRO   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INSERT    = 3'd1,
        ST_DIGIT     = 3'd2,
        ST_GAP       = 3'd3,
        ST_PIN_CHK   = 3'd4,
        ST_SEND_AMT  = 3'd5,
        ST_WAIT_RESP = 3'd6,
        ST_DONE      = 3'd7
    } estado_t;

    // Request captured from the host on an accepted start
    typedef struct packed {
        logic               tipo_tarjeta;
        logic               tipo_trans;
        logic [MONTO_W-1:0] monto;
        logic [PIN_W-1:0]   pin;
    } solicitud_t;

    // Counter width for a count of n cycles; never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cliente_cajero_serializador_pin.sv
// PIN serializer: shifts out one BCD digit per emit request, most significant first,
// and times the idle gap between digit strobes.
module serializador_pin
    import cajero_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [PIN_W-1:0]    i_pin,
    input  logic                i_emit,
    input  logic                i_gap,
    output logic [DIGITO_W-1:0] o_digito,
    output logic                o_digito_stb,
    output logic                o_gap_fin_c,
    output logic                o_last_c
);

    localparam int unsigned GAP_CW = cnt_w(GAP_CYCLES);
    localparam int unsigned IDX_W  = $clog2(N_DIGITOS + 1);
    localparam logic [GAP_CW-1:0] GAP_MAX = GAP_CW'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(N_DIGITOS);

    logic [PIN_W-1:0]    r_pin;
    logic [GAP_CW-1:0]   r_gap_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [DIGITO_W-1:0] r_digito;
    logic                r_stb;

    // Load, shift-out and gap counting; digit and index saturate after the last nibble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pin     <= '0;
            r_gap_cnt <= '0;
            r_idx     <= '0;
            r_digito  <= '0;
            r_stb     <= 1'b0;
        end else begin
            r_stb <= 1'b0;
            if (i_load) begin
                r_pin     <= i_pin;
                r_idx     <= '0;
                r_gap_cnt <= '0;
            end else if (i_emit && (r_idx != IDX_MAX)) begin
                r_digito  <= r_pin[PIN_W-1 -: DIGITO_W];
                r_pin     <= {r_pin[PIN_W-DIGITO_W-1:0], {DIGITO_W{1'b0}}};
                r_idx     <= r_idx + IDX_W'(1);
                r_gap_cnt <= '0;
                r_stb     <= 1'b1;
            end else if (i_gap && (r_gap_cnt != GAP_MAX)) begin
                r_gap_cnt <= r_gap_cnt + GAP_CW'(1);
            end
        end
    end

    assign o_digito     = r_digito;
    assign o_digito_stb = r_stb;
    assign o_gap_fin_c  = (r_gap_cnt == GAP_MAX);
    assign o_last_c     = (r_idx == IDX_MAX);

endmodule

// File: rtl/cliente_cajero.sv
// Customer-side driver: plays one host request into the ATM controller's
// strobe protocol and condenses the controller's flags into a result code.
module cliente_cajero
    import cajero_pkg::*;
#(
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned PIN_WAIT     = 4,
    parameter int unsigned RESP_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [PIN_W-1:0]    pin_in,
    input  logic                tipo_tarjeta_in,
    input  logic                tipo_trans_in,
    input  logic [MONTO_W-1:0]  monto_in,
    output logic                busy,
    output logic                done,
    output logic [RES_W-1:0]    resultado,
    output logic                advertencia_vista,
    output logic                tarjeta_recibida,
    output logic                tipo_de_tarjeta,
    output logic [DIGITO_W-1:0] digito,
    output logic                digito_stb,
    output logic                tipo_trans,
    output logic [MONTO_W-1:0]  monto,
    output logic                monto_stb,
    input  logic                balance_actualizado,
    input  logic                entregar_dinero,
    input  logic                fondos_insuficientes,
    input  logic                pin_incorrecto,
    input  logic                bloqueo,
    input  logic                advertencia
);

    localparam int unsigned PIN_CW  = cnt_w(PIN_WAIT);
    localparam int unsigned RESP_CW = cnt_w(RESP_TIMEOUT);
    localparam logic [PIN_CW-1:0]  PIN_MAX  = PIN_CW'(PIN_WAIT - 1);
    localparam logic [RESP_CW-1:0] RESP_MAX = RESP_CW'(RESP_TIMEOUT - 1);

    estado_t          r_estado;
    estado_t          w_estado_nxt;
    logic [RES_W-1:0] w_res_nxt;
    logic             w_acepta;
    logic             w_exito;

    logic [PIN_CW-1:0]  r_pin_cnt;
    logic [RESP_CW-1:0] r_resp_cnt;
    solicitud_t         r_sol;

    logic             r_busy;
    logic             r_done;
    logic [RES_W-1:0] r_resultado;
    logic             r_adv;
    logic             r_tarjeta;
    logic             r_monto_stb;

    logic                w_gap_fin;
    logic                w_last;
    logic [DIGITO_W-1:0] w_digito;
    logic                w_digito_stb;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado <= ST_IDLE;
        end else begin
            r_estado <= w_estado_nxt;
        end
    end

    // Next state and result selection; bloqueo overrides everything once a card is in
    always_comb begin
        w_estado_nxt = r_estado;
        w_res_nxt    = r_resultado;
        w_acepta     = 1'b0;
        w_exito      = ((r_sol.tipo_trans == TRANS_RETIRO)   && entregar_dinero) ||
                       ((r_sol.tipo_trans == TRANS_DEPOSITO) && balance_actualizado);
        case (r_estado)
            ST_IDLE: begin
                if (start) begin
                    w_acepta     = 1'b1;
                    w_estado_nxt = ST_INSERT;
                end
            end
            ST_INSERT: w_estado_nxt = ST_DIGIT;
            ST_DIGIT:  w_estado_nxt = w_last ? ST_PIN_CHK : ST_GAP;
            ST_GAP: begin
                if (w_gap_fin) begin
                    w_estado_nxt = ST_DIGIT;
                end
            end
            ST_PIN_CHK: begin
                if (pin_incorrecto) begin
                    w_estado_nxt = ST_DONE;
                    w_res_nxt    = RES_PIN_BAD;
                end else if (r_pin_cnt == PIN_MAX) begin
                    w_estado_nxt = ST_SEND_AMT;
                end
            end
            ST_SEND_AMT: w_estado_nxt = ST_WAIT_RESP;
            ST_WAIT_RESP: begin
                if (fondos_insuficientes) begin
                    w_estado_nxt = ST_DONE;
                    w_res_nxt    = RES_NOFUNDS;
                end else if (pin_incorrecto) begin
                    w_estado_nxt = ST_DONE;
                    w_res_nxt    = RES_PIN_BAD;
                end else if (w_exito) begin
                    w_estado_nxt = ST_DONE;
                    w_res_nxt    = RES_OK;
                end else if (r_resp_cnt == RESP_MAX) begin
                    w_estado_nxt = ST_DONE;
                    w_res_nxt    = RES_TIMEOUT;
                end
            end
            ST_DONE: w_estado_nxt = ST_IDLE;
            default: w_estado_nxt = ST_IDLE;
        endcase
        if (bloqueo && (r_estado != ST_IDLE) && (r_estado != ST_DONE)) begin
            w_estado_nxt = ST_DONE;
            w_res_nxt    = RES_BLOCKED;
        end
    end

    // Saturating window counters, cleared whenever their state is not active
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pin_cnt  <= '0;
            r_resp_cnt <= '0;
        end else begin
            if (r_estado != ST_PIN_CHK) begin
                r_pin_cnt <= '0;
            end else if (r_pin_cnt != PIN_MAX) begin
                r_pin_cnt <= r_pin_cnt + PIN_CW'(1);
            end
            if (r_estado != ST_WAIT_RESP) begin
                r_resp_cnt <= '0;
            end else if (r_resp_cnt != RESP_MAX) begin
                r_resp_cnt <= r_resp_cnt + RESP_CW'(1);
            end
        end
    end

    // Registered outputs derived from the upcoming state, plus request latch and warning flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_resultado <= '0;
            r_adv       <= 1'b0;
            r_tarjeta   <= 1'b0;
            r_monto_stb <= 1'b0;
            r_sol       <= '0;
        end else begin
            r_busy      <= (w_estado_nxt != ST_IDLE);
            r_done      <= (w_estado_nxt == ST_DONE);
            r_resultado <= w_res_nxt;
            r_tarjeta   <= (w_estado_nxt inside {ST_INSERT, ST_DIGIT, ST_GAP, ST_PIN_CHK,
                                                 ST_SEND_AMT, ST_WAIT_RESP});
            r_monto_stb <= (w_estado_nxt == ST_SEND_AMT);
            if (w_acepta) begin
                r_sol.tipo_tarjeta <= tipo_tarjeta_in;
                r_sol.tipo_trans   <= tipo_trans_in;
                r_sol.monto        <= monto_in;
                r_sol.pin          <= pin_in;
                r_adv              <= 1'b0;
            end else if ((r_estado != ST_IDLE) && advertencia) begin
                r_adv <= 1'b1;
            end
        end
    end

    serializador_pin #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_serializador (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_acepta),
        .i_pin        (pin_in),
        .i_emit       (w_estado_nxt == ST_DIGIT),
        .i_gap        (r_estado == ST_GAP),
        .o_digito     (w_digito),
        .o_digito_stb (w_digito_stb),
        .o_gap_fin_c  (w_gap_fin),
        .o_last_c     (w_last)
    );

    assign busy              = r_busy;
    assign done              = r_done;
    assign resultado         = r_resultado;
    assign advertencia_vista = r_adv;
    assign tarjeta_recibida  = r_tarjeta;
    assign tipo_de_tarjeta   = r_sol.tipo_tarjeta;
    assign tipo_trans        = r_sol.tipo_trans;
    assign monto             = r_sol.monto;
    assign monto_stb         = r_monto_stb;
    assign digito            = w_digito;
    assign digito_stb        = w_digito_stb;

endmodule

// File: tb/tb_cliente_cajero.sv
// Scoreboard bench for cliente_cajero: stimulus queues expected strobes/results,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_cliente_cajero;
    import cajero_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] pin_in;
    logic        tipo_tarjeta_in;
    logic        tipo_trans_in;
    logic [31:0] monto_in;
    logic        busy, done;
    logic [2:0]  resultado;
    logic        advertencia_vista, tarjeta_recibida, tipo_de_tarjeta;
    logic [3:0]  digito;
    logic        digito_stb, tipo_trans, monto_stb;
    logic [31:0] monto;
    logic        balance_actualizado, entregar_dinero, fondos_insuficientes;
    logic        pin_incorrecto, bloqueo, advertencia;

    cliente_cajero #(
        .GAP_CYCLES   (2),
        .PIN_WAIT     (4),
        .RESP_TIMEOUT (16)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .pin_in               (pin_in),
        .tipo_tarjeta_in      (tipo_tarjeta_in),
        .tipo_trans_in        (tipo_trans_in),
        .monto_in             (monto_in),
        .busy                 (busy),
        .done                 (done),
        .resultado            (resultado),
        .advertencia_vista    (advertencia_vista),
        .tarjeta_recibida     (tarjeta_recibida),
        .tipo_de_tarjeta      (tipo_de_tarjeta),
        .digito               (digito),
        .digito_stb           (digito_stb),
        .tipo_trans           (tipo_trans),
        .monto                (monto),
        .monto_stb            (monto_stb),
        .balance_actualizado  (balance_actualizado),
        .entregar_dinero      (entregar_dinero),
        .fondos_insuficientes (fondos_insuficientes),
        .pin_incorrecto       (pin_incorrecto),
        .bloqueo              (bloqueo),
        .advertencia          (advertencia)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int t0     = 0;
    int n_chk  = 0;
    int n_fail = 0;

    localparam int K_DIG  = 0;
    localparam int K_AMT  = 1;
    localparam int K_DONE = 2;

    localparam int P_ZERO   = 0;
    localparam int P_RES    = 1;
    localparam int P_BUSY   = 2;
    localparam int P_QEMPTY = 3;

    // {bloqueo, fondos, pin_incorrecto, entregar, balance, advertencia}
    localparam logic [5:0] F_BLQ = 6'b100000;
    localparam logic [5:0] F_FON = 6'b010000;
    localparam logic [5:0] F_PIN = 6'b001000;
    localparam logic [5:0] F_ENT = 6'b000100;
    localparam logic [5:0] F_BAL = 6'b000010;
    localparam logic [5:0] F_ADV = 6'b000001;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] data;
        logic        flag;
    } ev_t;

    typedef struct {
        int          id;
        logic [31:0] exp;
    } probe_t;

    ev_t    exp_q[$];
    probe_t probe_q[$];

    function automatic string kname(input int k);
        case (k)
            K_DIG:   return "digit";
            K_AMT:   return "amount";
            default: return "done";
        endcase
    endfunction

    function automatic string pname(input int id);
        case (id)
            P_ZERO:  return "outputs_zero";
            P_RES:   return "resultado_hold";
            P_BUSY:  return "busy_idle";
            default: return "pending_events";
        endcase
    endfunction

    function automatic logic [31:0] probe_act(input int id);
        case (id)
            P_ZERO:  return 32'({|monto, busy, done, resultado, advertencia_vista, tarjeta_recibida,
                                 tipo_de_tarjeta, digito, digito_stb, tipo_trans, monto_stb});
            P_RES:   return 32'(resultado);
            P_BUSY:  return 32'(busy);
            default: return 32'(exp_q.size());
        endcase
    endfunction

    // Compare one observed output event against the head of the scoreboard
    task automatic see(input int k, input int rel, input logic [31:0] d, input logic f);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s at cycle %0d data=%0h flag=%0b", kname(k), rel, d, f);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != rel || e.data != d || e.flag != f) begin
                n_fail++;
                $display("FAIL %s got kind=%s cyc=%0d data=%0h flag=%0b exp kind=%s cyc=%0d data=%0h flag=%0b",
                         kname(e.kind), kname(k), rel, d, f, kname(e.kind), e.cyc, e.data, e.flag);
            end
        end
    endtask

    // Monitor: static probes first, then strobe/done events
    always @(negedge clk) begin
        int          rel;
        probe_t      p;
        logic [31:0] a;
        rel = cyc - t0;
        while (probe_q.size() > 0) begin
            p = probe_q.pop_front();
            a = probe_act(p.id);
            n_chk++;
            if (a !== p.exp) begin
                n_fail++;
                $display("FAIL %s got %0h exp %0h", pname(p.id), a, p.exp);
            end
        end
        if (reset) begin
            if (digito_stb) see(K_DIG, rel, 32'(digito), 1'b0);
            if (monto_stb)  see(K_AMT, rel, monto, tipo_trans);
            if (done) begin
                see(K_DONE, rel, 32'(resultado), advertencia_vista);
                n_chk++;
                if (tarjeta_recibida !== 1'b0) begin
                    n_fail++;
                    $display("FAIL card_low_at_done got %0b exp 0", tarjeta_recibida);
                end
                n_chk++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_at_done got %0b exp 1", busy);
                end
            end
        end
    end

    task automatic exp_ev(input int k, input int c, input logic [31:0] d, input logic f);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.data = d;
        e.flag = f;
        exp_q.push_back(e);
    endtask

    task automatic exp_pin(input logic [15:0] p);
        logic [15:0] v;
        v = p;
        for (int k = 0; k < 4; k++) exp_ev(K_DIG, 2 + k * 3, 32'(v[15 - 4 * k -: 4]), 1'b0);
    endtask

    task automatic probe(input int id, input logic [31:0] e);
        probe_t p;
        p.id  = id;
        p.exp = e;
        probe_q.push_back(p);
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge
    task automatic wait_rel(input int n);
        while (cyc < t0 + n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [15:0] p, input logic ttar, input logic ttr, input logic [31:0] m);
        @(posedge clk);
        #1;
        pin_in          = p;
        tipo_tarjeta_in = ttar;
        tipo_trans_in   = ttr;
        monto_in        = m;
        start           = 1'b1;
        t0              = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic flags_at(input int n, input logic [5:0] f);
        wait_rel(n);
        {bloqueo, fondos_insuficientes, pin_incorrecto, entregar_dinero,
         balance_actualizado, advertencia} = f;
        @(posedge clk);
        #1;
        {bloqueo, fondos_insuficientes, pin_incorrecto, entregar_dinero,
         balance_actualizado, advertencia} = '0;
    endtask

    task automatic finish_txn(input logic [2:0] res);
        for (int i = 0; i < 60 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        probe(P_BUSY, 32'(0));
        probe(P_QEMPTY, 32'(0));
        probe(P_RES, 32'(res));
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b0;
        start           = 1'b0;
        pin_in          = '0;
        tipo_tarjeta_in = 1'b0;
        tipo_trans_in   = 1'b0;
        monto_in        = '0;
        {bloqueo, fondos_insuficientes, pin_incorrecto, entregar_dinero,
         balance_actualizado, advertencia} = '0;
        repeat (2) @(posedge clk);
        #1;
        probe(P_ZERO, 32'(0));
        probe(P_RES, 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Good deposit
        exp_pin(16'h1234);
        exp_ev(K_AMT, 16, 32'd500, TRANS_DEPOSITO);
        exp_ev(K_DONE, 21, 32'(RES_OK), 1'b0);
        issue(16'h1234, 1'b1, TRANS_DEPOSITO, 32'd500);
        flags_at(20, F_BAL);
        finish_txn(RES_OK);

        // Wrong PIN
        exp_pin(16'h4321);
        exp_ev(K_DONE, 14, 32'(RES_PIN_BAD), 1'b0);
        issue(16'h4321, 1'b0, TRANS_RETIRO, 32'd80);
        flags_at(13, F_PIN);
        finish_txn(RES_PIN_BAD);

        // Insufficient funds, balance flag in the same cycle must not win
        exp_pin(16'h9876);
        exp_ev(K_AMT, 16, 32'hFFFF_FFFF, TRANS_RETIRO);
        exp_ev(K_DONE, 19, 32'(RES_NOFUNDS), 1'b0);
        issue(16'h9876, 1'b0, TRANS_RETIRO, 32'hFFFF_FFFF);
        flags_at(18, F_FON | F_BAL);
        finish_txn(RES_NOFUNDS);

        // Block mid-PIN with a warning
        exp_ev(K_DIG, 2, 32'd0, 1'b0);
        exp_ev(K_DIG, 5, 32'd9, 1'b0);
        exp_ev(K_DONE, 7, 32'(RES_BLOCKED), 1'b1);
        issue(16'h0909, 1'b1, TRANS_DEPOSITO, 32'd10);
        flags_at(6, F_BLQ | F_ADV);
        finish_txn(RES_BLOCKED);

        // Timeout; warning flag from the previous transaction must be cleared
        exp_pin(16'h1111);
        exp_ev(K_AMT, 16, 32'd7, TRANS_DEPOSITO);
        exp_ev(K_DONE, 33, 32'(RES_TIMEOUT), 1'b0);
        issue(16'h1111, 1'b0, TRANS_DEPOSITO, 32'd7);
        finish_txn(RES_TIMEOUT);

        // Reset mid-PIN: outputs drop at once, no done for the aborted request
        exp_ev(K_DIG, 2, 32'd2, 1'b0);
        exp_ev(K_DIG, 5, 32'd4, 1'b0);
        exp_ev(K_DIG, 8, 32'd6, 1'b0);
        issue(16'h2468, 1'b1, TRANS_DEPOSITO, 32'd42);
        wait_rel(9);
        reset = 1'b0;
        probe(P_ZERO, 32'(0));
        probe(P_RES, 32'(0));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        probe(P_QEMPTY, 32'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Clean withdrawal after reset release
        exp_pin(16'h1357);
        exp_ev(K_AMT, 16, 32'd100, TRANS_RETIRO);
        exp_ev(K_DONE, 18, 32'(RES_OK), 1'b0);
        issue(16'h1357, 1'b1, TRANS_RETIRO, 32'd100);
        flags_at(17, F_ENT);
        finish_txn(RES_OK);

        // Start while busy is ignored: digits and type stay from the accepted request
        exp_pin(16'h5678);
        exp_ev(K_DONE, 14, 32'(RES_PIN_BAD), 1'b0);
        issue(16'h5678, 1'b0, TRANS_RETIRO, 32'd9);
        wait_rel(4);
        pin_in        = 16'h9999;
        tipo_trans_in = TRANS_DEPOSITO;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flags_at(13, F_PIN);
        finish_txn(RES_PIN_BAD);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
